max7219_frame_sequencer: RTL and testbench

// - Sequences a daisy chain of N_DEV MAX7219 8x8 LED drivers. Emits the 5-frame init set,

---
 rtl/max7219_frame_sequencer_pkg.sv | 26 ++
 rtl/max7219_fb.sv | 36 +++
 rtl/max7219_frame_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_max7219_frame_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_frame_sequencer_pkg.sv
// Shared MAX7219 register addresses, word packing and sequencer state encoding.
package max7219_frame_sequencer_pkg;

    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    localparam logic [2:0] INIT_LAST = 3'd4;
    localparam logic [2:0] ROW_LAST  = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRow,
        StGap,
        StInty
    } seq_state_e;

    function automatic logic [15:0] mk_word(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

endpackage

// File: rtl/max7219_fb.sv
// Framebuffer: 8 rows x N_DEV bytes, one write port, one whole-row read port.
module max7219_fb #(
    parameter int unsigned N_DEV = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [$clog2(8*N_DEV)-1:0]   waddr,
    input  logic [7:0]                   wdata,
    input  logic [2:0]                   rd_row,
    output logic [8*N_DEV-1:0]           rd_data
);

    localparam int unsigned AW = $clog2(8*N_DEV);

    logic [7:0] mem_q [8*N_DEV];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8*N_DEV; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Address is {row, dev}, so a row occupies N_DEV consecutive entries.
    always_comb begin
        rd_data = '0;
        for (int d = 0; d < N_DEV; d++) begin
            rd_data[8*d +: 8] = mem_q[AW'(int'(rd_row) * N_DEV + d)];
        end
    end

endmodule

// File: rtl/max7219_frame_sequencer.sv
// Drives a MAX7219 daisy chain: init register set, then continuous row refresh from a
// framebuffer, with on-the-fly intensity updates, over a valid/ready frame interface.
module max7219_frame_sequencer
    import max7219_frame_sequencer_pkg::*;
#(
    parameter int unsigned N_DEV       = 4,
    parameter logic [3:0]  INTENSITY   = 4'h3,
    parameter logic [2:0]  SCAN_LIMIT  = 3'd7,
    parameter int unsigned REFRESH_GAP = 1024
) (
    input  logic                        clk_in,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        fb_we,
    input  logic [$clog2(8*N_DEV)-1:0]  fb_addr,
    input  logic [7:0]                  fb_wdata,
    input  logic                        int_we,
    input  logic [3:0]                  int_val,
    output logic [16*N_DEV-1:0]         frm_data,
    output logic                        frm_valid,
    input  logic                        frm_ready,
    output logic                        init_done,
    output logic                        busy
);

    localparam int unsigned GW = (REFRESH_GAP > 0) ? $clog2(REFRESH_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((REFRESH_GAP > 0) ? REFRESH_GAP - 1 : 0);

    seq_state_e          state_q, state_d, res_state_q, res_state_d, nxt_state;
    logic [2:0]          idx_q, idx_d, res_idx_q, res_idx_d, nxt_idx;
    logic [GW-1:0]       gap_q, gap_d;
    logic [3:0]          int_q, int_d;
    logic                pend_q, pend_d;
    logic                en_q, restart_q, restart_d;
    logic                init_done_q, init_done_d;
    logic                frm_valid_q, frm_valid_d;
    logic [16*N_DEV-1:0] frm_data_q, frm_data_d, frame_w;
    logic [8*N_DEV-1:0]  row_bytes;
    logic [15:0]         init_word;
    logic                accepted, load;

    max7219_fb #(
        .N_DEV(N_DEV)
    ) u_fb (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .we     (fb_we),
        .waddr  (fb_addr),
        .wdata  (fb_wdata),
        .rd_row (idx_d),
        .rd_data(row_bytes)
    );

    assign accepted = frm_valid_q & frm_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        res_state_d = res_state_q;
        res_idx_d   = res_idx_q;
        nxt_state   = state_q;
        nxt_idx     = idx_q;
        gap_d       = gap_q;
        init_done_d = init_done_q;
        load        = 1'b0;
        int_d       = int_we ? int_val : int_q;
        pend_d      = pend_q | int_we;
        restart_d   = restart_q | (enable & ~en_q);

        unique case (state_q)
            StIdle: begin
                restart_d = 1'b0;
                if (enable) begin
                    state_d = StInit;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            StGap: begin
                if (!enable) begin
                    state_d     = StIdle;
                    init_done_d = 1'b0;
                    restart_d   = 1'b0;
                end else if (restart_q) begin
                    state_d     = StInit;
                    idx_d       = '0;
                    load        = 1'b1;
                    init_done_d = 1'b0;
                    restart_d   = 1'b0;
                end else if (gap_q == '0) begin
                    state_d = StRow;
                    idx_d   = '0;
                    load    = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                if (accepted) begin
                    case (state_q)
                        StInit: begin
                            if (idx_q == INIT_LAST) begin
                                nxt_state = StRow;
                                nxt_idx   = '0;
                            end else begin
                                nxt_idx = idx_q + 3'd1;
                            end
                        end
                        StRow: begin
                            if (idx_q != ROW_LAST) begin
                                nxt_idx = idx_q + 3'd1;
                            end else if (REFRESH_GAP == 0) begin
                                nxt_idx = '0;
                            end else begin
                                nxt_state = StGap;
                                nxt_idx   = '0;
                            end
                        end
                        default: begin
                            nxt_state = res_state_q;
                            nxt_idx   = res_idx_q;
                        end
                    endcase

                    if (!enable) begin
                        state_d     = StIdle;
                        init_done_d = 1'b0;
                        restart_d   = 1'b0;
                    end else if (restart_q) begin
                        state_d     = StInit;
                        idx_d       = '0;
                        load        = 1'b1;
                        init_done_d = 1'b0;
                        restart_d   = 1'b0;
                    end else begin
                        if (state_q == StInit && idx_q == INIT_LAST) begin
                            init_done_d = 1'b1;
                        end
                        // Intensity updates slot in between frames but never split the init set.
                        if (state_q != StInit && pend_q) begin
                            state_d     = StInty;
                            idx_d       = '0;
                            res_state_d = nxt_state;
                            res_idx_d   = nxt_idx;
                        end else begin
                            state_d = nxt_state;
                            idx_d   = nxt_idx;
                        end
                        load = (state_d != StGap);
                        if (state_d == StGap) begin
                            gap_d = GAP_LOAD;
                        end
                    end
                end
            end
        endcase

        // Either frame carrying the intensity satisfies any request pending so far.
        if (load && (state_d == StInty || (state_d == StInit && idx_d == 3'd1))) begin
            pend_d = int_we;
        end

        frm_valid_d = load | (frm_valid_q & ~accepted);
    end

    always_comb begin
        case (idx_d)
            3'd0:    init_word = mk_word(REG_DECODE, 8'h00);
            3'd1:    init_word = mk_word(REG_INTENSITY, {4'h0, int_q});
            3'd2:    init_word = mk_word(REG_SCANLIM, {5'h00, SCAN_LIMIT});
            3'd3:    init_word = mk_word(REG_SHUTDOWN, 8'h01);
            default: init_word = mk_word(REG_TEST, 8'h00);
        endcase

        frame_w = '0;
        unique case (state_d)
            StInit: frame_w = {N_DEV{init_word}};
            StInty: frame_w = {N_DEV{mk_word(REG_INTENSITY, {4'h0, int_q})}};
            StRow: begin
                for (int d = 0; d < N_DEV; d++) begin
                    frame_w[16*d +: 16] = mk_word(REG_DIGIT0 + {1'b0, idx_d}, row_bytes[8*d +: 8]);
                end
            end
            default: frame_w = '0;
        endcase

        frm_data_d = load ? frame_w : frm_data_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            res_state_q <= StIdle;
            res_idx_q   <= '0;
            gap_q       <= '0;
            int_q       <= INTENSITY;
            pend_q      <= 1'b0;
            en_q        <= 1'b0;
            restart_q   <= 1'b0;
            init_done_q <= 1'b0;
            frm_valid_q <= 1'b0;
            frm_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            res_state_q <= res_state_d;
            res_idx_q   <= res_idx_d;
            gap_q       <= gap_d;
            int_q       <= int_d;
            pend_q      <= pend_d;
            en_q        <= enable;
            restart_q   <= restart_d;
            init_done_q <= init_done_d;
            frm_valid_q <= frm_valid_d;
            frm_data_q  <= frm_data_d;
        end
    end

    assign frm_data  = frm_data_q;
    assign frm_valid = frm_valid_q;
    assign init_done = init_done_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected frames from a byte-array model of the display,
// a negedge monitor pops and compares every accepted frame and checks hold stability.
module tb_max7219_frame_sequencer;

    localparam int unsigned NDEV = 4;
    localparam int unsigned GAP  = 4;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fb_we;
    logic [4:0]  fb_addr;
    logic [7:0]  fb_wdata;
    logic        int_we;
    logic [3:0]  int_val;
    logic [63:0] frm_data;
    logic        frm_valid;
    logic        frm_ready;
    logic        init_done;
    logic        busy;

    max7219_frame_sequencer #(
        .N_DEV      (NDEV),
        .INTENSITY  (4'h3),
        .SCAN_LIMIT (3'd7),
        .REFRESH_GAP(GAP)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .enable   (enable),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_wdata (fb_wdata),
        .int_we   (int_we),
        .int_val  (int_val),
        .frm_data (frm_data),
        .frm_valid(frm_valid),
        .frm_ready(frm_ready),
        .init_done(init_done),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    // Reference model of the display contents and intensity register.
    logic [7:0]  mfb [8][NDEV];
    logic [3:0]  m_int;
    logic [63:0] expq [$];

    int nchk = 0;
    int nerr = 0;
    int acc_cnt = 0;
    logic        held = 1'b0;
    logic [63:0] held_data;
    logic [63:0] want_m;

    function automatic logic [63:0] rep4(input logic [15:0] w);
        return {w, w, w, w};
    endfunction

    function automatic logic [63:0] row_frame(input int r);
        logic [63:0] f;
        logic [3:0]  dig;
        dig = 4'(r + 1);
        for (int d = 0; d < NDEV; d++) f[16*d +: 16] = {4'h0, dig, mfb[r][d]};
        return f;
    endfunction

    task automatic push_init();
        expq.push_back(rep4(16'h0900));
        expq.push_back(rep4(16'h0A00 | 16'(m_int)));
        expq.push_back(rep4(16'h0B07));
        expq.push_back(rep4(16'h0C01));
        expq.push_back(rep4(16'h0F00));
    endtask

    task automatic push_rows(input int first, input int last);
        for (int r = first; r <= last; r++) expq.push_back(row_frame(r));
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_until(input int n, input bit always_ready);
        int t = 0;
        while (acc_cnt < n && t < 2000) begin
            frm_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
            cyc();
            t++;
        end
        check("frames accepted in budget", 64'(acc_cnt), 64'(n));
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!frm_valid && t < 50) begin
            cyc();
            t++;
        end
        check(name, 64'(frm_valid), 64'd1);
    endtask

    task automatic fb_write(input int r, input int d, input logic [7:0] b);
        fb_addr  = 5'(r * NDEV + d);
        fb_wdata = b;
        fb_we    = 1'b1;
        cyc();
        fb_we    = 1'b0;
    endtask

    always @(negedge clk_in) begin
        if (rst_n && frm_valid) begin
            if (held) begin
                nchk++;
                if (frm_data !== held_data) begin
                    nerr++;
                    $display("FAIL held frame stable: got %h, expected %h", frm_data, held_data);
                end
            end
            if (frm_ready) begin
                nchk++;
                if (expq.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected frame: got %h, expected none", frm_data);
                end else begin
                    want_m = expq.pop_front();
                    if (frm_data !== want_m) begin
                        nerr++;
                        $display("FAIL frame %0d: got %h, expected %h", acc_cnt + 1, frm_data,
                                 want_m);
                    end
                end
                acc_cnt++;
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = frm_data;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         g;
        rst_n = 1'b0; enable = 1'b0; fb_we = 1'b0; fb_addr = '0; fb_wdata = '0;
        int_we = 1'b0; int_val = '0; frm_ready = 1'b0;
        m_int = 4'h3;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset frm_valid", 64'(frm_valid), 64'd0);
        check("reset frm_data", frm_data, 64'd0);
        check("reset init_done", 64'(init_done), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Fill the framebuffer while idle; row 0 carries the known pattern.
        for (int r = 0; r < 8; r++) begin
            for (int d = 0; d < NDEV; d++) begin
                if (r == 0) b = (d == 3) ? 8'hAA : (d == 0) ? 8'h55 : 8'h00;
                else        b = 8'($urandom);
                mfb[r][d] = b;
                fb_write(r, d, b);
            end
        end
        check("idle busy", 64'(busy), 64'd0);

        push_init();
        push_rows(0, 7);
        push_rows(0, 4);
        enable = 1'b1;
        run_until(4, 1'b0);
        check("init_done before 5th", 64'(init_done), 64'd0);
        run_until(5, 1'b0);
        check("init_done after 5th", 64'(init_done), 64'd1);
        check("busy running", 64'(busy), 64'd1);

        // Stall on ROW2 of the second refresh.
        run_until(15, 1'b0);
        frm_ready = 1'b0;
        wait_valid("row2 presented");
        repeat (10) cyc();
        check("row2 still valid", 64'(frm_valid), 64'd1);

        // Two intensity requests while ROW4 is held: one INTY with the last value.
        run_until(17, 1'b0);
        frm_ready = 1'b0;
        wait_valid("row4 presented");
        int_we = 1'b1; int_val = 4'h9;
        cyc();
        int_val = 4'hC;
        cyc();
        int_we = 1'b0;
        cyc();
        m_int = 4'hC;
        expq.push_back(rep4(16'h0A0C));
        push_rows(5, 7);
        run_until(19, 1'b1);

        // ROW5 is now on the bus; a write to row5/dev1 must miss this frame.
        frm_ready = 1'b0;
        check("row5 presented", 64'(frm_valid), 64'd1);
        b = mfb[5][1] ^ 8'hFF;
        fb_write(5, 1, b);
        mfb[5][1] = b;
        push_rows(0, 7);
        push_rows(0, 2);

        run_until(22, 1'b1);
        g = 0;
        while (!frm_valid && g < 50) begin
            cyc();
            g++;
        end
        check("gap cycles", 64'(g), 64'(GAP));

        // Drop enable while ROW2 of the fourth refresh is held.
        run_until(32, 1'b0);
        frm_ready = 1'b0;
        wait_valid("row2 held for disable");
        enable = 1'b0;
        repeat (3) cyc();
        check("held after disable", 64'(frm_valid), 64'd1);
        run_until(33, 1'b1);
        frm_ready = 1'b0;
        repeat (3) cyc();
        check("disabled frm_valid", 64'(frm_valid), 64'd0);
        check("disabled init_done", 64'(init_done), 64'd0);
        check("disabled busy", 64'(busy), 64'd0);
        check("queue empty after disable", 64'(expq.size()), 64'd0);

        // Re-enable, then reset in the middle of INIT2.
        expq.push_back(rep4(16'h0900));
        expq.push_back(rep4(16'h0A00 | 16'(m_int)));
        enable = 1'b1;
        run_until(35, 1'b0);
        frm_ready = 1'b0;
        wait_valid("init2 presented");
        #3 rst_n = 1'b0;
        #1;
        check("async reset frm_valid", 64'(frm_valid), 64'd0);
        check("async reset frm_data", frm_data, 64'd0);
        check("async reset init_done", 64'(init_done), 64'd0);
        check("async reset busy", 64'(busy), 64'd0);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        m_int = 4'h3;
        for (int r = 0; r < 8; r++) for (int d = 0; d < NDEV; d++) mfb[r][d] = 8'h00;
        push_init();
        push_rows(0, 7);
        run_until(48, 1'b0);
        enable    = 1'b0;
        frm_ready = 1'b1;
        repeat (10) cyc();
        check("final frm_valid", 64'(frm_valid), 64'd0);
        check("final queue empty", 64'(expq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
